// File: rtl/lcd_reader.sv
// =====================================================================
// Module  : lcd_reader
// Brief   : Reads one byte from a character LCD over the 4-bit nibble bus,
//           with optional busy-flag polling.
// Revision: 1.0
// =====================================================================
`default_nettype none

module lcd_reader #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_EHIGH  = 12,
    parameter int unsigned T_GAP    = 50,
    parameter int unsigned T_HOLD   = 1,
    parameter int unsigned POLL_MAX = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    input  logic [3:0] lcd_db_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       active,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       timeout
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_EH1   = 3'd2;
    localparam logic [2:0] c_GAP   = 3'd3;
    localparam logic [2:0] c_EH2   = 3'd4;
    localparam logic [2:0] c_HOLD  = 3'd5;
    localparam logic [2:0] c_EVAL  = 3'd6;
    localparam logic [2:0] c_RGAP  = 3'd7;

    localparam logic [7:0]  c_LD_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0]  c_LD_EHIGH = 8'(T_EHIGH - 1);
    localparam logic [7:0]  c_LD_GAP   = 8'(T_GAP - 1);
    localparam logic [7:0]  c_LD_HOLD  = 8'(T_HOLD - 1);
    localparam logic [16:0] c_POLL_MAX = 17'(POLL_MAX);

    logic [2:0]  state_q, state_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [16:0] pcnt_inc;
    logic        rs_l_q, rs_l_d;
    logic        poll_l_q, poll_l_d;
    logic [3:0]  hi_q, hi_d;
    logic [3:0]  lo_q, lo_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        tcnt_zero;

    assign tcnt_zero = (tcnt_q == 8'd0);
    assign pcnt_inc  = {1'b0, pcnt_q} + 17'd1;

    // Timing counter is reloaded with (duration-1) on every state entry.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_zero ? tcnt_q : tcnt_q - 8'd1;
        pcnt_d    = pcnt_q;
        rs_l_d    = rs_l_q;
        poll_l_d  = poll_l_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            c_IDLE: begin
                if (req) begin
                    rs_l_d    = rs_sel & ~poll;
                    poll_l_d  = poll;
                    pcnt_d    = 16'd0;
                    timeout_d = 1'b0;
                    tcnt_d    = c_LD_SETUP;
                    state_d   = c_SETUP;
                end
            end
            c_SETUP: begin
                if (tcnt_zero) begin
                    tcnt_d  = c_LD_EHIGH;
                    state_d = c_EH1;
                end
            end
            c_EH1: begin
                if (tcnt_zero) begin
                    hi_d    = lcd_db_in;
                    tcnt_d  = c_LD_GAP;
                    state_d = c_GAP;
                end
            end
            c_GAP: begin
                if (tcnt_zero) begin
                    tcnt_d  = c_LD_EHIGH;
                    state_d = c_EH2;
                end
            end
            c_EH2: begin
                if (tcnt_zero) begin
                    lo_d    = lcd_db_in;
                    tcnt_d  = c_LD_HOLD;
                    state_d = c_HOLD;
                end
            end
            c_HOLD: begin
                if (tcnt_zero) begin
                    state_d = c_EVAL;
                end
            end
            c_EVAL: begin
                pcnt_d = pcnt_inc[15:0];
                // hi_q[3] is the busy flag when the byte came from the status register.
                if (poll_l_q && hi_q[3] && (pcnt_inc < c_POLL_MAX)) begin
                    tcnt_d  = c_LD_GAP;
                    state_d = c_RGAP;
                end else begin
                    rd_data_d = {hi_q, lo_q};
                    done_d    = 1'b1;
                    timeout_d = poll_l_q & hi_q[3];
                    state_d   = c_IDLE;
                end
            end
            c_RGAP: begin
                if (tcnt_zero) begin
                    tcnt_d  = c_LD_SETUP;
                    state_d = c_SETUP;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_IDLE;
            tcnt_q    <= 8'd0;
            pcnt_q    <= 16'd0;
            rs_l_q    <= 1'b0;
            poll_l_q  <= 1'b0;
            hi_q      <= 4'd0;
            lo_q      <= 4'd0;
            rd_data_q <= 8'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            pcnt_q    <= pcnt_d;
            rs_l_q    <= rs_l_d;
            poll_l_q  <= poll_l_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Bus controls decode straight from state so an async reset drops them at once.
    assign lcd_e   = (state_q == c_EH1) || (state_q == c_EH2);
    assign lcd_rw  = (state_q == c_SETUP) || (state_q == c_EH1) || (state_q == c_GAP) ||
                     (state_q == c_EH2) || (state_q == c_HOLD);
    assign lcd_rs  = rs_l_q;
    assign active  = (state_q != c_IDLE);
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign timeout = timeout_q;

endmodule

`default_nettype wire
